// File: rtl/stdp_weight_engine.sv
// stdp_weight_engine: walks the synapses one per cycle, applying stochastic saturating +/-1 STDP updates.
module stdp_weight_engine #(
    parameter int NUM_SYN = 16,
    parameter int W_BITS  = 3,
    parameter int P_BITS  = 7,
    parameter int INIT_W  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3*NUM_SYN-1:0]           cases,
    input  logic [P_BITS-1:0]              u_capture,
    input  logic [P_BITS-1:0]              u_minus,
    input  logic [P_BITS-1:0]              u_search,
    input  logic [P_BITS-1:0]              u_backoff,
    input  logic [P_BITS-1:0]              rand_val,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SYN)-1:0]     wr_addr,
    input  logic [W_BITS-1:0]              wr_data,
    output logic [W_BITS*NUM_SYN-1:0]      weights,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_SYN+1)-1:0]   n_inc,
    output logic [$clog2(NUM_SYN+1)-1:0]   n_dec
);
    localparam int AW = $clog2(NUM_SYN);
    localparam int CW = $clog2(NUM_SYN + 1);
    localparam logic [W_BITS-1:0] WMAX = '1;
    localparam logic [W_BITS-1:0] W0 = W_BITS'(INIT_W);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [2:0]          code_q [NUM_SYN];
    logic [2:0]          code_d [NUM_SYN];
    logic [P_BITS-1:0]   ucap_q, ucap_d, umin_q, umin_d, usrch_q, usrch_d, uback_q, uback_d;
    logic [W_BITS-1:0]   w_q [NUM_SYN];
    logic [W_BITS-1:0]   w_d [NUM_SYN];
    logic [CW-1:0]       n_inc_q, n_inc_d, n_dec_q, n_dec_d;
    logic [2:0]          c;
    logic [P_BITS-1:0]   p;
    logic                inc, fire;
    logic [W_BITS-1:0]   w_cur;

    always_comb begin
        c = code_q[idx_q];
        p = c == 3'b111 ? ucap_q  :
            c == 3'b110 ? umin_q  :
            c == 3'b100 ? usrch_q :
            c == 3'b010 ? uback_q : '0;
        inc = c == 3'b111 || c == 3'b100;
        fire = rand_val < p;
        w_cur = w_q[idx_q];
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        code_d = code_q;
        ucap_d = ucap_q;
        umin_d = umin_q;
        usrch_d = usrch_q;
        uback_d = uback_q;
        w_d = w_q;
        n_inc_d = n_inc_q;
        n_dec_d = n_dec_q;
        case (state_q)
            IDLE: begin
                // a preload coinciding with start lands first, so the pass sees it
                if (wr_en && int'(wr_addr) < NUM_SYN)
                    w_d[wr_addr] = wr_data;
                if (start) begin
                    for (int i = 0; i < NUM_SYN; i++)
                        code_d[i] = cases[3*i +: 3];
                    ucap_d = u_capture;
                    umin_d = u_minus;
                    usrch_d = u_search;
                    uback_d = u_backoff;
                    n_inc_d = '0;
                    n_dec_d = '0;
                    idx_d = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (fire && inc && w_cur != WMAX) begin
                    w_d[idx_q] = w_cur + W_BITS'(1);
                    n_inc_d = n_inc_q + CW'(1);
                end
                if (fire && !inc && w_cur != '0) begin
                    w_d[idx_q] = w_cur - W_BITS'(1);
                    n_dec_d = n_dec_q + CW'(1);
                end
                state_d = int'(idx_q) == NUM_SYN - 1 ? DONE : UPDATE;
                idx_d = int'(idx_q) == NUM_SYN - 1 ? idx_q : idx_q + AW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            code_q <= '{default: '0};
            ucap_q <= '0;
            umin_q <= '0;
            usrch_q <= '0;
            uback_q <= '0;
            w_q <= '{default: W0};
            n_inc_q <= '0;
            n_dec_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            code_q <= code_d;
            ucap_q <= ucap_d;
            umin_q <= umin_d;
            usrch_q <= usrch_d;
            uback_q <= uback_d;
            w_q <= w_d;
            n_inc_q <= n_inc_d;
            n_dec_q <= n_dec_d;
        end
    end

    always_comb begin
        weights = '0;
        for (int i = 0; i < NUM_SYN; i++)
            weights[W_BITS*i +: W_BITS] = w_q[i];
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign n_inc = n_inc_q;
    assign n_dec = n_dec_q;
endmodule

// File: tb/tb_stdp_weight_engine.sv
// tb_stdp_weight_engine: directed checks of the STDP engine with NUM_SYN=4, INIT_W=2.
module tb_stdp_weight_engine;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [11:0] cases = '0;
    logic [6:0]  u_capture = '0, u_minus = '0, u_search = '0, u_backoff = '0, rand_val = '0;
    logic        wr_en = 0;
    logic [1:0]  wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic [11:0] weights;
    logic        busy, done;
    logic [2:0]  n_inc, n_dec;
    int checks = 0, errors = 0, dones = 0;

    stdp_weight_engine #(.NUM_SYN(4), .W_BITS(3), .P_BITS(7), .INIT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cases(cases),
        .u_capture(u_capture), .u_minus(u_minus), .u_search(u_search), .u_backoff(u_backoff),
        .rand_val(rand_val), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .weights(weights), .busy(busy), .done(done), .n_inc(n_inc), .n_dec(n_dec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) dones++;
    endtask

    task automatic preload(input logic [1:0] a, input logic [2:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    initial begin
        #12;
        chk("rst_weights", 32'(weights), 32'h492);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ninc", 32'(n_inc), 0);
        chk("rst_ndec", 32'(n_dec), 0);
        @(negedge clk);
        rst = 0;
        tick();

        cases = 12'hFFF; u_capture = 127; rand_val = 0; start = 1;
        tick();
        start = 0;
        chk("cap_busy_c1", 32'(busy), 1);
        chk("cap_done_c1", 32'(done), 0);
        repeat (3) tick();
        chk("cap_done_c4", 32'(done), 0);
        tick();
        chk("cap_done_c5", 32'(done), 1);
        chk("cap_weights", 32'(weights), 32'h6DB);
        chk("cap_ninc", 32'(n_inc), 4);
        tick();
        chk("cap_done_c6", 32'(done), 0);
        chk("cap_busy_c6", 32'(busy), 0);

        preload(0, 7);
        preload(1, 0);
        chk("sat_preload", 32'(weights), 32'h6C7);
        cases = 12'h017; u_capture = 127; u_backoff = 127; rand_val = 0; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("sat_done", 32'(done), 1);
        chk("sat_weights", 32'(weights), 32'h6C7);
        chk("sat_ninc", 32'(n_inc), 0);
        chk("sat_ndec", 32'(n_dec), 0);
        tick();

        preload(0, 3);
        preload(1, 3);
        cases = 12'hBB6; u_minus = 64; start = 1;
        tick();
        start = 0; cases = '0; u_minus = 0; rand_val = 63;
        tick();
        chk("cmp_63", 32'(weights), 32'h6DA);
        rand_val = 64;
        tick();
        chk("cmp_64", 32'(weights), 32'h6DA);
        rand_val = 0;
        repeat (2) tick();
        chk("cmp_done", 32'(done), 1);
        chk("cmp_weights", 32'(weights), 32'h69A);
        chk("cmp_ndec", 32'(n_dec), 2);
        chk("cmp_ninc", 32'(n_inc), 0);
        tick();

        dones = 0;
        cases = '0; start = 1;
        tick();
        wr_en = 1; wr_addr = 0; wr_data = 7;
        repeat (5) tick();
        start = 0; wr_en = 0;
        chk("hs_idle", 32'(busy), 0);
        repeat (3) tick();
        chk("hs_done_once", 32'(dones), 1);
        chk("hs_no_write", 32'(weights), 32'h69A);

        cases = 12'h038; u_capture = 127; rand_val = 0;
        wr_en = 1; wr_addr = 1; wr_data = 5; start = 1;
        tick();
        wr_en = 0; start = 0;
        repeat (4) tick();
        chk("wrst_done", 32'(done), 1);
        chk("wrst_weights", 32'(weights), 32'h6B2);
        chk("wrst_ninc", 32'(n_inc), 1);
        tick();

        dones = 0;
        cases = 12'hFFF; start = 1;
        tick();
        start = 0;
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1;
        #1;
        chk("mid_weights", 32'(weights), 32'h492);
        chk("mid_busy_rst", 32'(busy), 0);
        chk("mid_ninc", 32'(n_inc), 0);
        #2;
        rst = 0;
        repeat (6) tick();
        chk("mid_no_done", 32'(dones), 0);
        chk("mid_idle", 32'(busy), 0);
        chk("mid_weights_after", 32'(weights), 32'h492);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
